regfile_mp: RTL

Parametrised multi-read-port register file for the single-cycle datapath, successor to the fixed 32x32, two-read-port file. Depth, width and read-port count are parameters. A synchronous reset starts a hardware clear sweep that zeroes every entry, replacing simulation-only initial values. Register 0 is optionally hardwired to zero. Sits between decode (read addresses) and writeback (write port).

---
 rtl/regfile_mp.sv | 124 ++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with NUM_RD combinational read ports
// and one write port.
// A synchronous reset starts a hardware sweep that zeroes every entry. The
// file stays busy, with writes refused, until the sweep finishes.
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> an accepted write is forwarded to matching read ports
//                in the same cycle.
//   undefined -> a read returns the pre-write contents in the write cycle.
module regfile_mp #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_ready,
    output logic                       busy
);

    localparam int DEPTH = 1 << ADDR_W;
    // The pointer is one bit wider than an address, so it stops at DEPTH
    // instead of wrapping back to entry 0.
    localparam logic [ADDR_W:0] PTR_LAST = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t              state_q;
    logic [ADDR_W:0]     ptr_q;
    logic                busy_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                wr_accept;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    assign busy      = busy_q;
    assign wr_ready  = ~busy_q;
    assign wr_accept = wr_en & ~busy_q;

    // Sequence the clear sweep after reset.
    // Busy is registered, so it drops on the same edge that writes the last entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    ptr_q <= ptr_q + PTR_ONE;
                    if (ptr_q == PTR_LAST) begin
                        state_q <= READY;
                        busy_q  <= 1'b0;
                    end
                end
                READY: begin
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Select the single storage write: a sweep zero while clearing, or an
    // accepted writeback when ready. Address 0 is never written while it is
    // hardwired to zero.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (rst) begin
            mem_we = 1'b0;
        end else if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q[ADDR_W-1:0];
            mem_wdata = '0;
        end else if (wr_accept && !(ZERO_REG != 0 && wr_addr == '0)) begin
            mem_we = 1'b1;
        end
    end

    // Storage array. It has no reset, so the sweep is the only way it is cleared.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Each read port is independent. The zero rules are applied last, so
    // they override the forwarded value.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] lane;

        assign ra = rd_addr[i*ADDR_W +: ADDR_W];

        // Produce lane i from storage, then apply forwarding and the zero rules.
        always_comb begin
            lane = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
            if (wr_accept && (wr_addr == ra)) begin
                lane = wr_data;
            end
`else
`endif
            if (busy_q || (ZERO_REG != 0 && ra == '0)) begin
                lane = '0;
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = lane;
    end

endmodule
